estagio_busca: RTL and testbench

Instruction-fetch (IF) stage of the pipelined MIPS core. It is the initiator side of the instruction-memory interface: it owns the PC, drives the byte address to the instruction ROM and consumes the returned word combinationally. It registers the IF/ID pipeline boundary and handles stall, branch/jump redirect and halt.

---
 rtl/estagio_busca.sv | 128 ++++++++++++
 tb/tb_estagio_busca.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/estagio_busca.sv
// rtl/estagio_busca.sv - MIPS instruction-fetch stage with IF/ID pipeline register
//
// Purpose: owns the PC, addresses the instruction ROM, registers the IF/ID
// boundary and handles stall, branch/jump redirect and permanent halt.
// Optional feature macro: BUSCA_CONTADOR_EN (adds the contador_busca fetch counter).
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous reset, active low
//   pc             byte address to instruction memory (the PC register)
//   instruction    ROM word for pc, same cycle
//   stall          hold PC and IF/ID
//   redirect       taken branch/jump resolved in ID
//   redirect_pc    redirect target (low two bits ignored)
//   halt           stop fetching until reset
//   instrucao_id   IF/ID instruction
//   pc_mais4_id    IF/ID PC+4
//   valido_id      IF/ID entry holds a real instruction
//   parado         high while halted
//   contador_busca count of valid IF/ID writes (BUSCA_CONTADOR_EN only)

module estagio_busca #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP        = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] instruction,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic [DATA_WIDTH-1:0] instrucao_id,
  output logic [DATA_WIDTH-1:0] pc_mais4_id,
  output logic                  valido_id,
  output logic                  parado
`ifdef BUSCA_CONTADOR_EN
  ,
  output logic [31:0]           contador_busca
`endif
);

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    RUN    = 2'd1,
    PARADO = 2'd2
  } estado_t;

  estado_t               estado;
  logic [DATA_WIDTH-1:0] pc_mais4;
  logic [DATA_WIDTH-1:0] alvo_alinhado;
  logic                  avanca;
  logic                  unused_alvo_lsbs;

  // Modulo-2^N add: the top word address wraps to zero.
  assign pc_mais4         = pc + DATA_WIDTH'(4);
  assign alvo_alinhado    = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  assign unused_alvo_lsbs = ^redirect_pc[1:0];

  // A real instruction enters IF/ID only on an unobstructed RUN edge.
  assign avanca = (estado == RUN) && !halt && !redirect && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado       <= INICIO;
      pc           <= RESET_PC;
      instrucao_id <= NOP;
      pc_mais4_id  <= '0;
      valido_id    <= 1'b0;
      parado       <= 1'b0;
    end else begin
      case (estado)
        INICIO: begin
          // Boot bubble: PC and IF/ID keep their reset values.
          if (halt) begin
            estado <= PARADO;
            parado <= 1'b1;
          end else begin
            estado <= RUN;
          end
        end
        RUN: begin
          if (halt) begin
            estado       <= PARADO;
            parado       <= 1'b1;
            instrucao_id <= NOP;
            valido_id    <= 1'b0;
          end else if (redirect) begin
            // Flush the wrong-path fetch; wins over stall.
            pc           <= alvo_alinhado;
            instrucao_id <= NOP;
            pc_mais4_id  <= '0;
            valido_id    <= 1'b0;
          end else if (!stall) begin
            pc           <= pc_mais4;
            instrucao_id <= instruction;
            pc_mais4_id  <= pc_mais4;
            valido_id    <= 1'b1;
          end
        end
        PARADO: begin
          // Frozen until reset; all control inputs ignored.
          parado    <= 1'b1;
          valido_id <= 1'b0;
        end
        default: begin
          estado <= INICIO;
        end
      endcase
    end
  end

`ifdef BUSCA_CONTADOR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      contador_busca <= '0;
    end else if (avanca) begin
      contador_busca <= contador_busca + 32'd1;
    end
  end
`else
  logic unused_avanca;
  assign unused_avanca = avanca;
`endif

endmodule

// File: tb/tb_estagio_busca.sv
// tb/tb_estagio_busca.sv - self-checking bench for estagio_busca

module tb_estagio_busca;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    logic        exp_valido;
    logic        exp_parado;
    logic [31:0] exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect, halt;
  logic [31:0] redirect_pc;
  logic [31:0] pc, instruction, instrucao_id, pc_mais4_id;
  logic        valido_id, parado;
  logic [31:0] contador_busca;

  logic        rst_n_w;
  logic [31:0] pc_w, instruction_w, instrucao_id_w, pc_mais4_id_w;
  logic        valido_id_w, parado_w;
  logic [31:0] contador_busca_w;

  int checks = 0;
  int failures = 0;

  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a * 32'd7 + 32'd1);
  endfunction

  assign instruction   = rom(pc);
  assign instruction_w = rom(pc_w);

  estagio_busca dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instrucao_id(instrucao_id), .pc_mais4_id(pc_mais4_id),
    .valido_id(valido_id), .parado(parado)
`ifdef BUSCA_CONTADOR_EN
    , .contador_busca(contador_busca)
`endif
  );

  estagio_busca #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n_w), .pc(pc_w), .instruction(instruction_w),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0), .halt(1'b0),
    .instrucao_id(instrucao_id_w), .pc_mais4_id(pc_mais4_id_w),
    .valido_id(valido_id_w), .parado(parado_w)
`ifdef BUSCA_CONTADOR_EN
    , .contador_busca(contador_busca_w)
`endif
  );

`ifndef BUSCA_CONTADOR_EN
  assign contador_busca   = 32'h0;
  assign contador_busca_w = 32'h0;
`endif

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [31:0] dpc,
                              input logic h, input logic [31:0] epc, input logic [31:0] ei,
                              input logic [31:0] e4, input logic ev, input logic ep,
                              input logic [31:0] ec);
    vec_t v;
    v.rst_n = r; v.stall = s; v.redirect = d; v.redirect_pc = dpc; v.halt = h;
    v.exp_pc = epc; v.exp_instr = ei; v.exp_pc4 = e4; v.exp_valido = ev;
    v.exp_parado = ep; v.exp_cnt = ec;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    rst_n_w = 1'b0;

    // Free run, stall, redirect with stall, misaligned redirect.
    vecs.push_back(mk(0,0,0,0,0, 32'h0, 32'h0, 32'h0, 0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 32'h0, 32'h0, 32'h0, 0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 32'h4, rom(32'h0), 32'h4, 1,0, 1));
    vecs.push_back(mk(1,0,0,0,0, 32'h8, rom(32'h4), 32'h8, 1,0, 2));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1,1,0,0,0, 32'h8, rom(32'h4), 32'h8, 1,0, 2));
    vecs.push_back(mk(1,0,0,0,0, 32'hC, rom(32'h8), 32'hC, 1,0, 3));
    vecs.push_back(mk(1,1,1,32'h40,0, 32'h40, 32'h0, 32'h0, 0,0, 3));
    vecs.push_back(mk(1,0,0,0,0, 32'h44, rom(32'h40), 32'h44, 1,0, 4));
    vecs.push_back(mk(1,0,1,32'h43,0, 32'h40, 32'h0, 32'h0, 0,0, 4));
    vecs.push_back(mk(1,0,0,0,0, 32'h44, rom(32'h40), 32'h44, 1,0, 5));
    vecs.push_back(mk(1,0,0,0,0, 32'h48, rom(32'h44), 32'h48, 1,0, 6));
    // Mid-run reset, run to 0x10, halt and stay frozen despite redirect.
    vecs.push_back(mk(0,0,0,0,0, 32'h0, 32'h0, 32'h0, 0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 32'h0, 32'h0, 32'h0, 0,0, 0));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk(1,0,0,0,0, 32'(4*i), rom(32'(4*(i-1))), 32'(4*i), 1,0, 32'(i)));
    vecs.push_back(mk(1,0,0,0,1, 32'h10, 32'h0, 32'h10, 0,1, 4));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1,i[0],1,32'h80,i[1], 32'h10, 32'h0, 32'h10, 0,1, 4));
    vecs.push_back(mk(0,0,1,32'h80,0, 32'h0, 32'h0, 32'h0, 0,0, 0));
    // Halt during the boot bubble.
    vecs.push_back(mk(1,0,0,0,1, 32'h0, 32'h0, 32'h0, 0,1, 0));
    vecs.push_back(mk(1,0,0,0,0, 32'h0, 32'h0, 32'h0, 0,1, 0));
    vecs.push_back(mk(0,0,0,0,0, 32'h0, 32'h0, 32'h0, 0,0, 0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; stall = vecs[i].stall; redirect = vecs[i].redirect;
      redirect_pc = vecs[i].redirect_pc; halt = vecs[i].halt;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      begin
        vec_t e;
        e = sb.pop_front();
        cmp("pc", i, pc, e.exp_pc);
        cmp("instrucao_id", i, instrucao_id, e.exp_instr);
        cmp("pc_mais4_id", i, pc_mais4_id, e.exp_pc4);
        cmp("valido_id", i, 32'(valido_id), 32'(e.exp_valido));
        cmp("parado", i, 32'(parado), 32'(e.exp_parado));
`ifdef BUSCA_CONTADOR_EN
        cmp("contador_busca", i, contador_busca, e.exp_cnt);
`endif
      end
    end

    // Wrap: RESET_PC=0xFFFF_FFFC rolls over to 0.
    rst_n_w = 1'b0;
    @(posedge clk); #1;
    cmp("wrap_reset_pc", 0, pc_w, 32'hFFFF_FFFC);
    rst_n_w = 1'b1;
    @(posedge clk); #1;
    cmp("wrap_boot_pc", 1, pc_w, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    cmp("wrap_pc", 2, pc_w, 32'h0);
    cmp("wrap_pc4", 2, pc_mais4_id_w, 32'h0);
    cmp("wrap_instr", 2, instrucao_id_w, rom(32'hFFFF_FFFC));
    cmp("wrap_valido", 2, 32'(valido_id_w), 32'h1);
    @(posedge clk); #1;
    cmp("wrap_pc_next", 3, pc_w, 32'h4);
    cmp("wrap_instr_next", 3, instrucao_id_w, rom(32'h0));
    cmp("wrap_parado", 3, 32'(parado_w), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
